ppa_multiword_seq: RTL

- Sequencer that performs one WORDS*8-bit add or subtract by time-multiplexing a single 8-bit parallel-prefix adder, one word per cycle, LSB word first.
- Drives the adder's a/b/cin inputs and registers its sum/cout each cycle, chaining the carry through a carry register.
- Sits between a valid/ready requester and the combinational 8-bit adder; the adder itself is instantiated by the parent, not inside this block.

---
 rtl/ppa_pkg.sv | 22 ++
 rtl/ppa_multiword_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ppa_pkg.sv
// Shared definitions for the multi-word prefix-adder sequencer:
// FSM state encoding, adder word width and first-carry selection.
package ppa_pkg;

    localparam int PPA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ppa_state_e;

    // Subtract is A + ~B + 1, so the first word always sees carry-in 1.
    function automatic logic first_carry(input logic sub, input logic cin);
        if (sub) begin
            return 1'b1;
        end else begin
            return cin;
        end
    endfunction

endpackage

// File: rtl/ppa_multiword_seq.sv
// Time-multiplexes one external 8-bit prefix adder to perform a WORDS*8-bit
// add or subtract, one word per cycle, LSB word first.
module ppa_multiword_seq
    import ppa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDS*8-1:0]   in_a,
    input  logic [WORDS*8-1:0]   in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORDS*8-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic [7:0]           adder_a,
    output logic [7:0]           adder_b,
    output logic                 adder_cin,
    input  logic [7:0]           adder_sum,
    input  logic                 adder_cout
);

    localparam int W  = PPA_W;
    localparam int N  = WORDS * W;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    ppa_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_sub;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_res;
    logic            r_cout;
    logic            r_ovf;

    logic [W-1:0]    w_a_word;
    logic [W-1:0]    w_b_eff;
    logic            w_last;
    logic            w_ovf;

    // Current operand words; B is inverted when subtracting.
    always_comb begin
        w_a_word = r_a[int'(r_cnt)*W +: W];
        w_b_eff  = r_b[int'(r_cnt)*W +: W] ^ {W{r_sub}};
        w_last   = (r_cnt == LAST_IDX);
        w_ovf    = (w_a_word[W-1] == w_b_eff[W-1]) && (adder_sum[W-1] != w_a_word[W-1]);
    end

    // Adder bus is only driven while a word is in flight; quiet otherwise.
    always_comb begin
        if (r_state == ST_RUN) begin
            adder_a   = w_a_word;
            adder_b   = w_b_eff;
            adder_cin = r_carry;
        end else begin
            adder_a   = 8'h00;
            adder_b   = 8'h00;
            adder_cin = 1'b0;
        end
    end

    // Sequencer FSM, operand capture and per-word result/carry accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a     <= {N{1'b0}};
            r_b     <= {N{1'b0}};
            r_res   <= {N{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_sub   <= in_sub;
                        r_carry <= first_carry(in_sub, in_cin);
                        r_cnt   <= {CW{1'b0}};
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res[int'(r_cnt)*W +: W] <= adder_sum;
                    r_carry                   <= adder_cout;
                    // Counter parks on the last index instead of wrapping.
                    if (w_last) begin
                        r_cout  <= adder_cout;
                        r_ovf   <= w_ovf;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_res;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule
